// File: rtl/adc_seq_pkg.sv
// rtl/adc_seq_pkg.sv - shared state encoding, command bytes and settle helper for the ADC power sequencer
package adc_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_ANA_UP,
    ST_ADC_UP,
    ST_ON_IDLE,
    ST_ON_OUT,
    ST_DRAIN,
    ST_ADC_DN
  } adc_seq_state_e;

  localparam logic [7:0] CMD_PWR_UP  = 8'h50;  // 'P'
  localparam logic [7:0] CMD_PWR_DN  = 8'h70;  // 'p'
  localparam logic [7:0] CMD_OUT_ON  = 8'h4F;  // 'O'
  localparam logic [7:0] CMD_OUT_OFF = 8'h6F;  // 'o'

  // Terminal count for an N-cycle interval; a zero interval still lasts one cycle.
  function automatic int unsigned settle_term(input int unsigned cycles);
    return (cycles == 0) ? 0 : cycles - 1;
  endfunction

endpackage

// File: rtl/adc_seq_if.sv
// rtl/adc_seq_if.sv - command channel between the UART decoder and the power sequencer
interface adc_seq_if;
  logic [7:0] Cmd;
  logic       CmdValid;
  logic       CmdError;

  modport master (output Cmd, output CmdValid, input CmdError);
  modport slave  (input Cmd, input CmdValid, output CmdError);
endinterface

// File: rtl/adc_seq_timer.sv
// rtl/adc_seq_timer.sv - settle/timeout counter shared by every timed sequencer state
module adc_seq_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done_o = en_i && (cnt_q == term_i);

  // Holds at the terminal value so a late state change never sees a wrapped count.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i && !done_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_power_sequencer.sv
// rtl/adc_power_sequencer.sv - ordered ADC rail sequencer driven by ASCII commands; ADC_SEQ_WATCHDOG_EN adds an ON_IDLE timeout
module adc_power_sequencer
  import adc_seq_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int ANA_SETTLE   = 16,
  parameter int ADC_SETTLE   = 8,
  parameter int OUT_DRAIN    = 4,
  parameter int ADC_DOWN     = 8,
  parameter int IDLE_TIMEOUT = 1000
) (
  input  logic            Clock,
  input  logic            Reset,
  adc_seq_if.slave        cmd_if,
  output logic            AnalogPower,
  output logic            ADCPower,
  output logic            OutToADCEnable,
  output logic            Ready,
  output logic            Busy
);

  localparam longint CNT_LIM = longint'(1) << CNT_W;

  if (ANA_SETTLE >= CNT_LIM || ADC_SETTLE >= CNT_LIM || OUT_DRAIN >= CNT_LIM ||
      ADC_DOWN >= CNT_LIM || IDLE_TIMEOUT >= CNT_LIM) begin : g_cnt_w_check
    $error("adc_power_sequencer: interval parameter does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] T_ANA   = CNT_W'(settle_term(ANA_SETTLE));
  localparam logic [CNT_W-1:0] T_ADC   = CNT_W'(settle_term(ADC_SETTLE));
  localparam logic [CNT_W-1:0] T_DRAIN = CNT_W'(settle_term(OUT_DRAIN));
  localparam logic [CNT_W-1:0] T_DN    = CNT_W'(settle_term(ADC_DOWN));
`ifdef ADC_SEQ_WATCHDOG_EN
  localparam logic [CNT_W-1:0] T_WDT   = CNT_W'(settle_term(IDLE_TIMEOUT));
`endif

  adc_seq_state_e   state_q, state_d;
  logic             err_q, err_d;
  logic             ana_q, adc_q, out_q, rdy_q, busy_q;
  logic             tmr_load, tmr_en, tmr_done;
  logic [CNT_W-1:0] tmr_term;

  adc_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i  (Clock),
    .rst_i  (Reset),
    .load_i (tmr_load),
    .en_i   (tmr_en),
    .term_i (tmr_term),
    .done_o (tmr_done)
  );

  always_comb begin
    tmr_term = '0;
    case (state_q)
      ST_ANA_UP:  tmr_term = T_ANA;
      ST_ADC_UP:  tmr_term = T_ADC;
      ST_DRAIN:   tmr_term = T_DRAIN;
      ST_ADC_DN:  tmr_term = T_DN;
`ifdef ADC_SEQ_WATCHDOG_EN
      ST_ON_IDLE: tmr_term = T_WDT;
`endif
      default:    tmr_term = '0;
    endcase
  end

  // Commands win over a same-cycle terminal count, so an abort is never lost.
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    if (cmd_if.CmdValid) begin
      case (cmd_if.Cmd)
        CMD_PWR_UP: begin
          if (state_q == ST_OFF) state_d = ST_ANA_UP;
          else                   err_d   = 1'b1;
        end
        CMD_PWR_DN: begin
          case (state_q)
            ST_ANA_UP:              state_d = ST_OFF;
            ST_ADC_UP, ST_ON_IDLE:  state_d = ST_ADC_DN;
            ST_ON_OUT:              state_d = ST_DRAIN;
            default:                err_d   = 1'b1;
          endcase
        end
        CMD_OUT_ON: begin
          if (state_q == ST_ON_IDLE || state_q == ST_ON_OUT) state_d = ST_ON_OUT;
          else                                               err_d   = 1'b1;
        end
        CMD_OUT_OFF: begin
          if (state_q == ST_ON_IDLE || state_q == ST_ON_OUT) state_d = ST_ON_IDLE;
          else                                               err_d   = 1'b1;
        end
        default: err_d = 1'b1;
      endcase
    end

    if (state_d == state_q && tmr_done) begin
      case (state_q)
        ST_ANA_UP: state_d = ST_ADC_UP;
        ST_ADC_UP: state_d = ST_ON_IDLE;
        ST_DRAIN:  state_d = ST_ADC_DN;
        ST_ADC_DN: state_d = ST_OFF;
`ifdef ADC_SEQ_WATCHDOG_EN
        ST_ON_IDLE: begin
          if (!cmd_if.CmdValid) begin
            state_d = ST_ADC_DN;
            err_d   = 1'b1;
          end
        end
`endif
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    tmr_en   = (state_q == ST_ANA_UP) || (state_q == ST_ADC_UP) ||
               (state_q == ST_DRAIN)  || (state_q == ST_ADC_DN);
    tmr_load = (state_d != state_q);
`ifdef ADC_SEQ_WATCHDOG_EN
    tmr_en   = tmr_en || (state_q == ST_ON_IDLE);
    tmr_load = tmr_load || ((state_q == ST_ON_IDLE) && cmd_if.CmdValid);
`endif
  end

  // Rails are decoded from the next state so they move on the same edge as the state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_OFF;
      err_q   <= 1'b0;
      ana_q   <= 1'b0;
      adc_q   <= 1'b0;
      out_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      ana_q   <= (state_d != ST_OFF);
      adc_q   <= (state_d == ST_ADC_UP) || (state_d == ST_ON_IDLE) ||
                 (state_d == ST_ON_OUT) || (state_d == ST_DRAIN);
      out_q   <= (state_d == ST_ON_OUT);
      rdy_q   <= (state_d == ST_ON_IDLE) || (state_d == ST_ON_OUT);
      busy_q  <= (state_d == ST_ANA_UP) || (state_d == ST_ADC_UP) ||
                 (state_d == ST_DRAIN)  || (state_d == ST_ADC_DN);
    end
  end

  assign AnalogPower     = ana_q;
  assign ADCPower        = adc_q;
  assign OutToADCEnable  = out_q;
  assign Ready           = rdy_q;
  assign Busy            = busy_q;
  assign cmd_if.CmdError = err_q;

  a_rail_order: assert property (@(posedge Clock) (!out_q || adc_q) && (!adc_q || ana_q));

endmodule

// File: tb/tb_adc_power_sequencer.sv
// tb/tb_adc_power_sequencer.sv - directed self-checking bench for adc_power_sequencer
module tb_adc_power_sequencer;
  import adc_seq_pkg::*;

  logic Clock = 1'b0;
  logic Reset;
  logic AnalogPower, ADCPower, OutToADCEnable, Ready, Busy;
  int   n_cmp = 0;
  int   n_bad = 0;

  adc_seq_if cmd_if();

  adc_power_sequencer #(
    .CNT_W(16), .ANA_SETTLE(16), .ADC_SETTLE(8), .OUT_DRAIN(4), .ADC_DOWN(8), .IDLE_TIMEOUT(20)
  ) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .cmd_if         (cmd_if),
    .AnalogPower    (AnalogPower),
    .ADCPower       (ADCPower),
    .OutToADCEnable (OutToADCEnable),
    .Ready          (Ready),
    .Busy           (Busy)
  );

  always #5 Clock = ~Clock;

  // {AnalogPower, ADCPower, OutToADCEnable, Ready, Busy}
  localparam logic [4:0] R_OFF   = 5'b00000;
  localparam logic [4:0] R_ANA   = 5'b10001;
  localparam logic [4:0] R_ADCON = 5'b11001;
  localparam logic [4:0] R_IDLE  = 5'b11010;
  localparam logic [4:0] R_OUT   = 5'b11110;
  localparam logic [4:0] R_DN    = 5'b10001;

  logic [4:0] rails;
  assign rails = {AnalogPower, ADCPower, OutToADCEnable, Ready, Busy};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    cmd_if.Cmd      = b;
    cmd_if.CmdValid = 1'b1;
    tick();
    cmd_if.CmdValid = 1'b0;
    cmd_if.Cmd      = 8'h00;
  endtask

  always @(negedge Clock) begin
    if (Reset === 1'b0) begin
      chk("rail_order", {6'd0, (OutToADCEnable && !ADCPower), (ADCPower && !AnalogPower)}, 8'h00);
    end
  end

  initial begin
    logic [4:0] exp_r;
    Reset = 1'b1;
    cmd_if.Cmd = 8'h00;
    cmd_if.CmdValid = 1'b0;
    tick(); tick();
    chk("reset_rails", {3'd0, rails}, {3'd0, R_OFF});
    chk("reset_err", {7'd0, cmd_if.CmdError}, 8'h00);
    Reset = 1'b0;
    tick();

    // Power-up timing with default settles
    send(CMD_PWR_UP);
    chk("pu_ana", {3'd0, rails}, {3'd0, R_ANA});
    for (int i = 1; i <= 24; i++) begin
      tick();
      exp_r = (i < 16) ? R_ANA : (i < 24) ? R_ADCON : R_IDLE;
      chk($sformatf("pu_step%0d", i), {3'd0, rails}, {3'd0, exp_r});
    end
    chk("pu_err", {7'd0, cmd_if.CmdError}, 8'h00);

    // Outputs on, then ordered power-down through DRAIN
    send(CMD_OUT_ON);
    chk("out_on", {3'd0, rails}, {3'd0, R_OUT});
    send(CMD_PWR_DN);
    chk("pd_drain", {3'd0, rails}, {3'd0, R_ADCON});
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_r = (i < 4) ? R_ADCON : (i < 12) ? R_DN : R_OFF;
      chk($sformatf("pd_step%0d", i), {3'd0, rails}, {3'd0, exp_r});
    end

    // Abort in ANA_UP goes straight to OFF
    send(CMD_PWR_UP);
    repeat (4) tick();
    send(CMD_PWR_DN);
    chk("abort_ana_rails", {3'd0, rails}, {3'd0, R_OFF});
    chk("abort_ana_err", {7'd0, cmd_if.CmdError}, 8'h00);
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("abort_ana_stay", {3'd0, rails}, {3'd0, R_OFF});
    end

    // Rejected commands
    send(CMD_OUT_ON);
    chk("rej_O_off_err", {7'd0, cmd_if.CmdError}, 8'h01);
    chk("rej_O_off_rails", {3'd0, rails}, {3'd0, R_OFF});
    tick();
    chk("rej_err_pulse", {7'd0, cmd_if.CmdError}, 8'h00);
    send(CMD_PWR_UP);
    repeat (24) tick();
    chk("rej_idle", {3'd0, rails}, {3'd0, R_IDLE});
    send(CMD_PWR_UP);
    chk("rej_P_idle_err", {7'd0, cmd_if.CmdError}, 8'h01);
    chk("rej_P_idle_rails", {3'd0, rails}, {3'd0, R_IDLE});
    send(8'h41);
    chk("rej_41_err", {7'd0, cmd_if.CmdError}, 8'h01);
    chk("rej_41_rails", {3'd0, rails}, {3'd0, R_IDLE});
    send(CMD_OUT_OFF);
    chk("redund_o_err", {7'd0, cmd_if.CmdError}, 8'h00);
    chk("redund_o_rails", {3'd0, rails}, {3'd0, R_IDLE});
    send(CMD_OUT_ON);
    send(CMD_PWR_DN);
    send(CMD_PWR_DN);
    chk("rej_p_drain_err", {7'd0, cmd_if.CmdError}, 8'h01);
    chk("rej_p_drain_rails", {3'd0, rails}, {3'd0, R_ADCON});
    repeat (10) tick();
    chk("drain_not_off", {3'd0, rails}, {3'd0, R_DN});
    tick();
    chk("drain_off", {3'd0, rails}, {3'd0, R_OFF});

    // Abort in ADC_UP goes through ADC_DN
    send(CMD_PWR_UP);
    repeat (17) tick();
    send(CMD_PWR_DN);
    chk("abort_adc_rails", {3'd0, rails}, {3'd0, R_DN});
    chk("abort_adc_err", {7'd0, cmd_if.CmdError}, 8'h00);
    repeat (7) tick();
    chk("abort_adc_dn", {3'd0, rails}, {3'd0, R_DN});
    tick();
    chk("abort_adc_off", {3'd0, rails}, {3'd0, R_OFF});

    // Reset while in ON_OUT drops everything, then restart
    send(CMD_PWR_UP);
    repeat (24) tick();
    send(CMD_OUT_ON);
    chk("rst_pre", {3'd0, rails}, {3'd0, R_OUT});
    Reset = 1'b1;
    tick();
    chk("rst_rails", {3'd0, rails}, {3'd0, R_OFF});
    Reset = 1'b0;
    send(CMD_PWR_UP);
    chk("rst_restart", {3'd0, rails}, {3'd0, R_ANA});
    repeat (23) tick();
    chk("rst_restart_busy", {3'd0, rails}, {3'd0, R_ADCON});
    tick();
    chk("rst_restart_ready", {3'd0, rails}, {3'd0, R_IDLE});

`ifdef ADC_SEQ_WATCHDOG_EN
    // Watchdog: 'o' at cycle 15 restarts the 20-cycle idle count
    repeat (14) tick();
    send(CMD_OUT_OFF);
    chk("wdt_o_err", {7'd0, cmd_if.CmdError}, 8'h00);
    repeat (19) tick();
    chk("wdt_hold", {3'd0, rails}, {3'd0, R_IDLE});
    tick();
    chk("wdt_fire_rails", {3'd0, rails}, {3'd0, R_DN});
    chk("wdt_fire_err", {7'd0, cmd_if.CmdError}, 8'h01);
    repeat (7) tick();
    chk("wdt_dn", {3'd0, rails}, {3'd0, R_DN});
    tick();
    chk("wdt_off", {3'd0, rails}, {3'd0, R_OFF});
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_power_sequencer.md
Name: adc_power_sequencer

Overview:
Command-driven sequencer that owns the ADC board's power and output-enable rails. It enforces the order analog supply, then ADC supply, then ADC output drivers on power-up, and the reverse order on power-down. A settle interval is inserted at each step. It sits between the UART command decoder (ASCII byte stream) and the ADC front end, and replaces direct rail toggling.

Parameters:
CNT_W, 16, width of the settle/timeout counter
ANA_SETTLE, 16, cycles AnalogPower is held before ADCPower asserts (0 treated as 1)
ADC_SETTLE, 8, cycles ADCPower is held before Ready asserts (0 treated as 1)
OUT_DRAIN, 4, cycles between OutToADCEnable deassert and ADCPower deassert on power-down (0 treated as 1)
ADC_DOWN, 8, cycles between ADCPower deassert and AnalogPower deassert (0 treated as 1)
IDLE_TIMEOUT, 1000, watchdog limit in cycles (optional feature only)

Ports:
Clock  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high reset
Cmd  in  8  ASCII command byte
CmdValid  in  1  Cmd qualifier; one-cycle strobe per command
AnalogPower  out  1  analog supply enable
ADCPower  out  1  ADC digital supply enable
OutToADCEnable  out  1  ADC output driver enable
Ready  out  1  high in ON_IDLE and ON_OUT
Busy  out  1  high in any timed transition state
CmdError  out  1  one-cycle pulse: command rejected or unknown

Behaviour:
- Reset (synchronous, active-high): state OFF, counter 0, all outputs 0. Reset mid-sequence drops all rails in the same cycle; no ordered shutdown.
- Commands are sampled only when CmdValid=1. Cmd is don't-care (may be X/Z) when CmdValid=0.
- Command set: 'P' (0x50) power up; 'p' (0x70) power down; 'O' (0x4F) outputs on; 'o' (0x6F) outputs off. Any other byte gives a CmdError pulse, with no state change.
- States and transitions:
  - OFF: 'P' goes to ANA_UP.
  - ANA_UP: AnalogPower=1. Count ANA_SETTLE cycles, then go to ADC_UP.
  - ADC_UP: AnalogPower=1, ADCPower=1. Count ADC_SETTLE cycles, then go to ON_IDLE.
  - ON_IDLE: both rails on, Ready=1. 'O' goes to ON_OUT; 'p' goes to ADC_DN.
  - ON_OUT: as ON_IDLE, plus OutToADCEnable=1. 'o' goes to ON_IDLE; 'p' goes to DRAIN.
  - DRAIN: OutToADCEnable=0, both rails on. Count OUT_DRAIN cycles, then go to ADC_DN.
  - ADC_DN: ADCPower=0, AnalogPower=1. Count ADC_DOWN cycles, then go to OFF.
- Outputs are registered and decoded from state. Each changes in the cycle after the causing command edge or terminal count.
- Power-up latency: 'P' sampled at edge N.
  - AnalogPower rises at N+1.
  - ADCPower rises at N+1+ANA_SETTLE.
  - Ready rises at N+1+ANA_SETTLE+ADC_SETTLE.
- Abort during power-up:
  - 'p' in ANA_UP goes straight to OFF (ADC never powered).
  - 'p' in ADC_UP goes to ADC_DN.
- Rejected commands: each gives a one-cycle CmdError pulse.
  - 'P' in any state other than OFF.
  - 'O' or 'o' in any state other than ON_IDLE/ON_OUT.
  - 'p' in OFF, DRAIN or ADC_DN.
- Redundant 'O' in ON_OUT and 'o' in ON_IDLE are accepted silently (no error).
- Counter: cleared on every state entry, terminal count at param−1. Settle parameters must be < 2^CNT_W (elaboration check). No wrap-around is reachable.
- Busy=1 in ANA_UP, ADC_UP, DRAIN, ADC_DN.
- Invariant (checked): OutToADCEnable implies ADCPower, and ADCPower implies AnalogPower, in every cycle.

Optional Feature:
ADC_SEQ_WATCHDOG_EN
- Defined: a counter runs in ON_IDLE only, restarted by any valid command. On reaching IDLE_TIMEOUT the block enters ADC_DN and emits a one-cycle CmdError pulse.
- Undefined: ON_IDLE holds indefinitely and the IDLE_TIMEOUT parameter is unused.

Decomposition:
- Package adc_seq_pkg holds:
  - the state enum (OFF, ANA_UP, ADC_UP, ON_IDLE, ON_OUT, DRAIN, ADC_DN);
  - ASCII command constants CMD_PWR_UP, CMD_PWR_DN, CMD_OUT_ON, CMD_OUT_OFF.
- Sub-module adc_seq_timer provides the loadable down/up counter: load and enable inputs, done output, width CNT_W. It is shared by all timed states.

Test Plan:
1. Defaults. 'P' at edge 10 -> AnalogPower=1 at 11, ADCPower=1 at 27, Ready=1 at 35, Busy=1 over 11..34.
2. From ON_IDLE: 'O' -> OutToADCEnable=1 next cycle. Then 'p' -> OutToADCEnable=0 next cycle, ADCPower=0 4 cycles later, AnalogPower=0 8 cycles after that, state OFF.
3. 'p' 5 cycles after 'P' (in ANA_UP) -> AnalogPower=0 next cycle, ADCPower never rises, no CmdError.
4. 'O' while OFF, 'P' while ON_IDLE, and byte 0x41 -> one CmdError pulse each; rails unchanged.
5. Reset high for 1 cycle while in ON_OUT -> all outputs 0 next cycle. A following 'P' restarts the full sequence.
6. With ADC_SEQ_WATCHDOG_EN and IDLE_TIMEOUT=20: no commands for 20 cycles in ON_IDLE -> CmdError pulse, ADCPower=0, then OFF after ADC_DOWN cycles. Also, an 'o' at cycle 15 restarts the count.
